// File: rtl/regfile_if.sv
// Register-file access bus: one write port and two independent read ports.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// Register file with hard-wired zero register, one write port and two
// combinational read ports with write-first bypass.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  // r0 has no storage; it reads as zero through the read logic.
  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Storage: async clear on reset, otherwise write r[waddr] when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (bus.we) begin
      for (int i = 1; i < NREG; i++)
        if (bus.waddr == ADDR_W'(i)) regs[i] <= bus.wdata;
    end
  end

  // Read port 1: zero in reset / for r0 / when disabled, bypass same-cycle write.
  always_comb begin
    rd1 = '0;
    if (rst && bus.re1 && bus.raddr1 != '0) begin
      if (bus.we && bus.raddr1 == bus.waddr) begin
        rd1 = bus.wdata;
      end else begin
        for (int i = 1; i < NREG; i++)
          if (bus.raddr1 == ADDR_W'(i)) rd1 = regs[i];
      end
    end
  end

  // Read port 2: same resolution as port 1, fully independent.
  always_comb begin
    rd2 = '0;
    if (rst && bus.re2 && bus.raddr2 != '0) begin
      if (bus.we && bus.raddr2 == bus.waddr) begin
        rd2 = bus.wdata;
      end else begin
        for (int i = 1; i < NREG; i++)
          if (bus.raddr2 == ADDR_W'(i)) rd2 = regs[i];
      end
    end
  end

  assign bus.rdata1 = rd1;
  assign bus.rdata2 = rd2;
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed cases plus randomized traffic
// against an array-based reference model.
module tb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [NR];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [DW-1:0] ref_read(input logic re, input logic [AW-1:0] ra);
    if (!rst || ra == 0 || !re) return '0;
    if (bus.we && ra == bus.waddr) return bus.wdata;
    return model[ra];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re1, input logic [AW-1:0] ra1,
                       input logic re2, input logic [AW-1:0] ra2);
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.re1 = re1; bus.raddr1 = ra1;
    bus.re2 = re2; bus.raddr2 = ra2;
  endtask

  task automatic check_reads(input string tag);
    check({tag, ".p1"}, bus.rdata1, ref_read(bus.re1, bus.raddr1));
    check({tag, ".p2"}, bus.rdata2, ref_read(bus.re2, bus.raddr2));
  endtask

  // Advance one clock: model commits at the rising edge, return on falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst && bus.we && bus.waddr != 0) model[bus.waddr] = bus.wdata;
    @(negedge clk);
  endtask

  task automatic cyc(input string tag);
    #1 check_reads(tag);
    tick();
  endtask

  initial begin
    logic [AW-1:0] wa;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;

    clear_model();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);

    // Held in reset: reads zero and writes ignored even with everything enabled.
    drive(1'b1, 5'd4, 32'h12345678, 1'b1, 5'd4, 1'b1, 5'd3);
    #1 check("rst_hold.p1", bus.rdata1, '0);
    check("rst_hold.p2", bus.rdata2, '0);
    tick();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 5'd4, 1'b0, '0);
    #1 check("rst_nowrite", bus.rdata1, '0);
    @(negedge clk);

    // First write right after reset release is accepted.
    drive(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, '0, 1'b0, '0);
    cyc("first_wr");
    drive(1'b0, '0, '0, 1'b1, 5'd12, 1'b0, '0);
    #1 check("first_wr_rd", bus.rdata1, 32'hCAFEF00D);
    tick();

    // Unwritten registers read zero (r12 excluded, written above).
    for (int a = 1; a < NR; a++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(a));
      #1 check("init_zero", bus.rdata1, (a == 12) ? 32'hCAFEF00D : 32'h0);
    end
    @(negedge clk);

    // Write r5, read on enabled port 1 and disabled port 2.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0);
    cyc("w5");
    drive(1'b0, '0, '0, 1'b1, 5'd5, 1'b0, 5'd5);
    #1 check("r5_en", bus.rdata1, 32'hDEADBEEF);
    check("r5_dis", bus.rdata2, 32'h0);
    tick();

    // Writes to r0 are dropped and never bypassed.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    #1 check("r0_same", bus.rdata1, 32'h0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
    #1 check("r0_after", bus.rdata1, 32'h0);
    tick();

    // Write-first bypass on both ports, then the stored value.
    drive(1'b1, 5'd7, 32'h11111111, 1'b0, '0, 1'b0, '0);
    cyc("w7a");
    drive(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7);
    #1 check("byp.p1", bus.rdata1, 32'h22222222);
    check("byp.p2", bus.rdata2, 32'h22222222);
    tick();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd7);
    #1 check("post_byp.p1", bus.rdata1, 32'h22222222);
    check("post_byp.p2", bus.rdata2, 32'h22222222);
    tick();

    // No bypass without we, and no update.
    drive(1'b1, 5'd9, 32'h3, 1'b0, '0, 1'b0, '0);
    cyc("w9");
    drive(1'b0, 5'd9, 32'h5, 1'b1, 5'd9, 1'b0, '0);
    #1 check("nobyp", bus.rdata1, 32'h3);
    tick();
    drive(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0);
    #1 check("nobyp_after", bus.rdata1, 32'h3);
    tick();

    // Async reset between edges wipes r3 immediately and permanently.
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 1'b0, '0);
    cyc("w3");
    drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0);
    #1 check("r3_before", bus.rdata1, 32'hA5A5A5A5);
    #1 rst = 1'b0;
    clear_model();
    #1 check("r3_async", bus.rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("r3_release", bus.rdata1, 32'h0);
    tick();
    #1 check("r3_later", bus.rdata1, 32'h0);
    @(negedge clk);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 600; n++) begin
      wa  = AW'($urandom_range(0, NR - 1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, NR - 1));
      drive(1'($urandom_range(0, 1)), wa, $urandom(),
            ($urandom_range(0, 7) != 0), ra1, ($urandom_range(0, 7) != 0), ra2);
      #1 check_reads("rnd");
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b0;
        clear_model();
        #1 check_reads("rnd_rst");
      end
      tick();
      if (!rst) begin
        rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
